// File: rtl/demux_1x3_handshake_if.sv
// Handshake bundle between the upstream producer, the 1-to-3 distributor and its three consumers.
interface demux_1x3_handshake_if #(
    parameter int unsigned W = 32
);
    // Upstream side
    logic [1:0]   select;
    logic [W-1:0] data_in;
    logic         in_valid;
    logic         in_ready;

    // Consumer side, one buffered word per channel
    logic [W-1:0] ch_0;
    logic [W-1:0] ch_1;
    logic [W-1:0] ch_2;
    logic [2:0]   ch_valid;
    logic [2:0]   ch_ready;

    // Environment view: producer plus consumers
    modport master (
        output select, data_in, in_valid, ch_ready,
        input  in_ready, ch_0, ch_1, ch_2, ch_valid
    );

    // Distributor view
    modport slave (
        input  select, data_in, in_valid, ch_ready,
        output in_ready, ch_0, ch_1, ch_2, ch_valid
    );
endinterface

// File: rtl/demux_1x3_handshake.sv
// Registered 1-to-3 result distributor: steers each accepted word into one of
// three single-entry buffers, each drained independently by its own consumer.
module demux_1x3_handshake #(
    parameter int unsigned W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    demux_1x3_handshake_if.slave  bus,
    output logic                  sel_err,
    output logic                  busy
);
    localparam int unsigned N_CH = 3;

    logic [1:0]             dest_c;
    logic                   accept_c;
    logic [N_CH-1:0]        drain_c;

    logic [N_CH-1:0]        full_q;
    logic [N_CH-1:0]        full_d;
    logic [N_CH-1:0][W-1:0] data_q;
    logic [N_CH-1:0][W-1:0] data_d;
    logic                   sel_err_q;
    logic                   sel_err_d;

    // Destination decode; the reserved code 2'b11 falls back to channel 0.
    always_comb begin
        dest_c = 2'd0;
        case (bus.select)
            2'b01:   dest_c = 2'd1;
            2'b10:   dest_c = 2'd2;
            default: dest_c = 2'd0;
        endcase
    end

    // Ready looks only at the selected buffer so a stalled channel never blocks the others.
    assign bus.in_ready = ~full_q[dest_c] | bus.ch_ready[dest_c];
    assign accept_c     = bus.in_valid & bus.in_ready;
    assign drain_c      = full_q & bus.ch_ready;

    // Next state: drains first, then a load re-fills its buffer (drain+load keeps it full).
    always_comb begin
        full_d    = full_q & ~drain_c;
        data_d    = data_q;
        sel_err_d = sel_err_q;
        if (accept_c) begin
            full_d[dest_c] = 1'b1;
            data_d[dest_c] = bus.data_in;
            if (bus.select == 2'b11) begin
                sel_err_d = 1'b1;
            end
        end
    end

    // Buffer and flag registers; reset discards any in-flight words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q    <= '0;
            data_q    <= '0;
            sel_err_q <= 1'b0;
        end else begin
            full_q    <= full_d;
            data_q    <= data_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign bus.ch_0     = data_q[0];
    assign bus.ch_1     = data_q[1];
    assign bus.ch_2     = data_q[2];
    assign bus.ch_valid = full_q;
    assign sel_err      = sel_err_q;
    assign busy         = |full_q;
endmodule

// File: tb/tb_demux_1x3_handshake.sv
// Randomized and directed bench for demux_1x3_handshake against a per-channel occupancy model.
module tb_demux_1x3_handshake;
    logic clk = 1'b0;
    logic rst;
    logic sel_err;
    logic busy;

    demux_1x3_handshake_if #(.W(32)) bus ();

    demux_1x3_handshake #(.W(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .sel_err (sel_err),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: number of words held per channel (0 or 1), last word loaded, error flag.
    int          m_cnt  [3];
    logic [31:0] m_data [3];
    logic        m_err;
    logic        m_acc;

    // DUT values sampled mid-cycle before the edge, for directed literal checks.
    logic        mid_rdy;
    logic [2:0]  mid_valid;
    logic [31:0] mid_ch0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dest_of(input logic [1:0] s);
        return (s == 2'b01) ? 1 : (s == 2'b10) ? 2 : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i]  = 0;
            m_data[i] = 32'h0;
        end
        m_err = 1'b0;
        m_acc = 1'b0;
    endtask

    // Compare every DUT output against the model for the current cycle.
    task automatic check_model();
        logic [2:0] ev;
        logic       er;
        int         d;
        d  = dest_of(bus.select);
        er = (m_cnt[d] == 0) || bus.ch_ready[d];
        for (int i = 0; i < 3; i++) ev[i] = (m_cnt[i] != 0);
        chk("ch_valid", 32'(bus.ch_valid), 32'(ev));
        chk("ch_0", bus.ch_0, m_data[0]);
        chk("ch_1", bus.ch_1, m_data[1]);
        chk("ch_2", bus.ch_2, m_data[2]);
        chk("busy", 32'(busy), 32'(ev != 3'b000));
        chk("sel_err", 32'(sel_err), 32'(m_err));
        chk("in_ready", 32'(bus.in_ready), 32'(er));
    endtask

    // One clock cycle: drive, check mid-cycle, then advance the model across the edge.
    task automatic step(input logic [1:0] s, input logic [31:0] d, input logic v, input logic [2:0] r);
        int dst;
        bus.select   = s;
        bus.data_in  = d;
        bus.in_valid = v;
        bus.ch_ready = r;
        #3;
        check_model();
        mid_rdy   = bus.in_ready;
        mid_valid = bus.ch_valid;
        mid_ch0   = bus.ch_0;
        @(posedge clk);
        dst   = dest_of(s);
        m_acc = v && ((m_cnt[dst] == 0) || r[dst]);
        for (int i = 0; i < 3; i++)
            if (m_cnt[i] > 0 && r[i]) m_cnt[i]--;
        if (m_acc) begin
            m_cnt[dst]++;
            m_data[dst] = d;
            if (s == 2'b11) m_err = 1'b1;
        end
        #1;
    endtask

    // Random traffic that honours the hold-until-accepted rule but may retarget while stalled.
    task automatic random_phase(input int cycles, input int sel3_weight);
        logic [1:0]  s;
        logic [31:0] d;
        logic        v;
        logic        hold;
        hold = 1'b0;
        s = 2'b00;
        d = 32'h0;
        v = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            if (!hold) begin
                v = ($urandom_range(0, 3) != 0);
                d = $urandom;
                s = 2'($urandom_range(0, 2));
                if ($urandom_range(0, 99) < sel3_weight) s = 2'b11;
            end else if ($urandom_range(0, 3) == 0) begin
                s = 2'($urandom_range(0, 2));
            end
            step(s, d, v, 3'($urandom_range(0, 7)));
            hold = v && !m_acc;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.select   = 2'b00;
        bus.data_in  = 32'h0;
        bus.in_valid = 1'b0;
        bus.ch_ready = 3'b000;
        model_reset();

        // Reset state
        #3;
        chk("rst_valid", 32'(bus.ch_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(sel_err), 32'h0);
        chk("rst_ready", 32'(bus.in_ready), 32'h1);
        check_model();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single routes into each channel, then a stall on a full channel
        step(2'b00, 32'hA5A5A5A5, 1'b1, 3'b000);
        chk("route0_valid", 32'(bus.ch_valid), 32'h1);
        chk("route0_data", bus.ch_0, 32'hA5A5A5A5);
        step(2'b01, 32'h12345678, 1'b1, 3'b000);
        chk("route1_valid", 32'(bus.ch_valid), 32'h3);
        chk("route1_data", bus.ch_1, 32'h12345678);
        step(2'b10, 32'hDEADBEEF, 1'b1, 3'b000);
        chk("route2_valid", 32'(bus.ch_valid), 32'h7);
        chk("route2_data", bus.ch_2, 32'hDEADBEEF);
        step(2'b01, 32'h99999999, 1'b1, 3'b000);
        chk("full_stall", 32'(mid_rdy), 32'h0);

        // Back-pressure on ch_1 does not block ch_0 and ch_2
        step(2'b00, 32'h00000001, 1'b1, 3'b001);
        chk("bp_acc0", 32'(mid_rdy), 32'h1);
        step(2'b10, 32'h00000002, 1'b1, 3'b100);
        chk("bp_acc2", 32'(mid_rdy), 32'h1);
        chk("bp_ch1", bus.ch_1, 32'h12345678);
        chk("bp_ch1_valid", 32'(bus.ch_valid[1]), 32'h1);

        // Streaming into ch_2 with all consumers ready
        step(2'b00, 32'h0, 1'b0, 3'b111);
        for (int i = 0; i < 8; i++) begin
            step(2'b10, 32'(i), 1'b1, 3'b111);
            chk("stream_rdy", 32'(mid_rdy), 32'h1);
            chk("stream_data", bus.ch_2, 32'(i));
        end
        step(2'b00, 32'h0, 1'b0, 3'b111);
        step(2'b10, 32'd8, 1'b1, 3'b011);
        chk("stream_w8", 32'(mid_rdy), 32'h1);
        step(2'b10, 32'd9, 1'b1, 3'b011);
        chk("stream_w9_stall", 32'(mid_rdy), 32'h0);
        chk("stream_hold8", bus.ch_2, 32'd8);

        // Simultaneous drain and load on ch_0
        step(2'b00, 32'h11, 1'b1, 3'b000);
        step(2'b00, 32'h22, 1'b1, 3'b001);
        chk("dl_rdy", 32'(mid_rdy), 32'h1);
        chk("dl_old", mid_ch0, 32'h11);
        chk("dl_new", bus.ch_0, 32'h22);
        chk("dl_valid", 32'(bus.ch_valid[0]), 32'h1);

        // Reserved select routes to ch_0 and latches the error flag
        step(2'b11, 32'hCAFEF00D, 1'b1, 3'b001);
        chk("ill_data", bus.ch_0, 32'hCAFEF00D);
        chk("ill_valid", 32'(bus.ch_valid[0]), 32'h1);
        chk("ill_err", 32'(sel_err), 32'h1);
        step(2'b01, 32'h5, 1'b1, 3'b111);
        step(2'b00, 32'h6, 1'b1, 3'b111);
        chk("ill_sticky", 32'(sel_err), 32'h1);

        random_phase(300, 10);

        // Asynchronous reset with all three buffers full
        step(2'b00, 32'h0, 1'b0, 3'b111);
        step(2'b00, 32'hAAAA0000, 1'b1, 3'b000);
        step(2'b01, 32'hBBBB1111, 1'b1, 3'b000);
        step(2'b10, 32'hCCCC2222, 1'b1, 3'b000);
        chk("ar_full", 32'(bus.ch_valid), 32'h7);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", 32'(bus.ch_valid), 32'h0);
        chk("ar_ch0", bus.ch_0, 32'h0);
        chk("ar_ch1", bus.ch_1, 32'h0);
        chk("ar_ch2", bus.ch_2, 32'h0);
        chk("ar_busy", 32'(busy), 32'h0);
        chk("ar_err", 32'(sel_err), 32'h0);
        chk("ar_ready", 32'(bus.in_ready), 32'h1);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fresh traffic without reserved selects: the flag must stay clear
        random_phase(200, 0);
        chk("clean_err", 32'(sel_err), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/demux_1x3_handshake.md
# demux_1x3_handshake

Registered 1-to-3 result distributor for the CORDIC coprocessor datapath: the inverse of the 3-to-1 channel selector. It takes one W-bit word per accepted transfer from the upstream producer and steers it, under a 2-bit select, into one of three single-entry output buffers. Each buffer has its own valid/ready handshake toward its consumer, for example the X, Y and Z result registers or the output interface. Back-pressure on one channel does not block traffic to the other two.

## Interface
- W, 32: data word width.

- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- select  input  2  destination: 2'b00 is ch_0, 2'b01 is ch_1, 2'b10 is ch_2, 2'b11 is ch_0 (flagged).
- data_in  input  W  word to route.
- in_valid  input  1  upstream offers data_in/select this cycle.
- in_ready  output  1  block accepts this cycle (combinational).
- ch_0, ch_1, ch_2  output  W each  buffered word per channel.
- ch_valid  output  3  bit i: channel i buffer holds an undelivered word.
- ch_ready  input  3  bit i: consumer i takes ch_i this cycle.
- sel_err  output  1  sticky: a transfer with select=2'b11 was accepted.
- busy  output  1  OR of ch_valid.

## Operation
- State per channel i: full_i (drives ch_valid[i]) and data_i (drives ch_i). Plus sel_err.
- dest is computed from select: 01 gives 1, 10 gives 2, 00 and 11 give 0.
- in_ready = !full_dest | ch_ready[dest]. It depends only on the selected channel. It is valid even when in_valid=0.
- Accept occurs when in_valid & in_ready. On accept: data_dest <= data_in and full_dest <= 1.
- Drain occurs when full_i & ch_ready[i]. On drain with no simultaneous load of i: full_i <= 0.
- Simultaneous drain and load on the same channel: full stays 1 and data is replaced. The consumer gets the old word this cycle and the new word from the next cycle.
- Drains on different channels, and a load on a third channel, all occur in the same cycle independently.
- data_i is not cleared on drain. It holds the last value until the next load.
- select=2'b11 with accept: routes to ch_0 and sets sel_err <= 1. sel_err holds until rst.
- select=2'b11 without accept: no flag.
- ch_ready[i] while full_i=0: ignored, no state change.
- Upstream must hold data_in, select and in_valid stable until accepted. Changing select while stalled is legal; the new dest is re-evaluated combinationally.

## Timing
- Reset (async assert, any cycle, including mid-transfer): full_i=0, ch_i=0, ch_valid=3'b000, sel_err=0, busy=0. in_ready=1 while rst is high; no accept occurs during reset.
- Any in-flight buffered word is discarded by reset.
- Latency: a word accepted at edge n appears on ch_dest with ch_valid set after edge n, one cycle.
- Throughput: 1 word/cycle into one channel when its ch_ready is held 1. Otherwise 1 word per channel until that channel drains.
- Full-buffer stall: in_ready=0 exactly when full_dest=1 and ch_ready[dest]=0.
- Combinational paths: ch_ready to in_ready, and select to in_ready. There is no path from data_in to any output.

## Test plan
- Reset then single routes: after rst, send 0xA5A5A5A5 with sel=00, 0x12345678 with sel=01, 0xDEADBEEF with sel=10, ch_ready=000. Required: ch_valid goes 001, 011, 111 on successive cycles with matching ch_x values. A 4th word with sel=01 sees in_ready=0.
- Independent back-pressure: ch_1 full with ch_ready[1]=0. Send 0x1 with sel=00 while ch_ready[0]=1, then sel=10. Required: both accepted in consecutive cycles; ch_1 is unchanged.
- Streaming: ch_ready=111, sel=10, 8 back-to-back words 0..7. Required: in_ready=1 every cycle and ch_2 shows 0..7 one cycle delayed. Then drop ch_ready[2]: word 8 is accepted, word 9 stalls.
- Simultaneous drain+load on ch_0: ch_0 holds 0x11, ch_ready[0]=1, accept 0x22 on sel=00. Required: 0x11 is consumed that cycle, next cycle ch_0=0x22 with ch_valid[0]=1, and no bubble.
- Illegal select: accept 0xCAFEF00D with sel=11. Required: ch_0=0xCAFEF00D, ch_valid[0]=1, sel_err=1. sel_err stays 1 through later legal traffic until rst.
- Async reset mid-operation: all three buffers full; assert rst between clock edges. Required: ch_valid=000, ch_*=0, busy=0, sel_err=0 immediately, without waiting for a clock edge.
